msrv32_branch_predict_ctrl: RTL and testbench
=============================================

Name: msrv32_branch_predict_ctrl

Overview:
- Branch prediction and misprediction-recovery controller around msrv32_branch_unit.
- Keeps a direct-mapped table of 2-bit saturating counters and predicts conditional branches (opcode[6:2]=5'b11000) at fetch.
- At execute, it takes branch_taken from the branch unit, updates the table, and on a mispredict drives a registered PC redirect plus a multi-cycle pipeline flush.

Parameters:
- IDX_W, 4, table index width; table has 2**IDX_W entries, index = pc[IDX_W+1:2].
- FLUSH_CYCLES, 2, cycles flush_out stays high after a mispredict (legal range 1..7).

Ports:
- ms_riscv32_mp_clk_in  input  1  system clock, rising edge.
- ms_riscv32_mp_rst_in  input  1  asynchronous, active-high reset.
- fetch_valid_in  input  1  fetch-stage instruction valid.
- fetch_pc_in  input  32  fetch PC.
- fetch_opcode_in  input  5  instruction opcode[6:2] at fetch.
- fetch_imm_in  input  32  sign-extended B-type immediate at fetch.
- predict_taken_out  output  1  prediction for the current fetch (combinational).
- predict_pc_out  output  32  predicted next PC (combinational).
- resolve_valid_in  input  1  execute-stage instruction valid.
- resolve_pc_in  input  32  PC of the resolving instruction.
- resolve_opcode_in  input  5  opcode[6:2] of the resolving instruction.
- resolve_pred_taken_in  input  1  prediction made for this instruction at fetch.
- branch_taken_in  input  1  branch_taken_out from msrv32_branch_unit.
- resolve_target_in  input  32  computed branch target (pc+imm).
- redirect_valid_out  output  1  one-cycle registered redirect pulse.
- redirect_pc_out  output  32  correct PC; valid only when redirect_valid_out=1.
- flush_out  output  1  kill younger instructions in IF/ID.
- mispredict_count_out  output  16  saturating mispredict counter.

Behaviour:
- Reset (async, immediate, also mid-flush):
  - all counters = 2'b01 (weakly not-taken); state = IDLE.
  - redirect_valid_out=0, redirect_pc_out=0, flush_out=0, mispredict_count_out=0.
- Prediction (combinational):
  - predict_taken_out = fetch_valid_in & (fetch_opcode_in==5'b11000) & ctr[fidx][1].
  - predict_pc_out = predict_taken_out ? fetch_pc_in+fetch_imm_in : fetch_pc_in+4.
  - Additions are 32-bit and wrap modulo 2**32.
  - Table read returns the pre-edge value; there is no bypass from a same-cycle update.
- Resolve qualifier: rq = resolve_valid_in & (resolve_opcode_in==5'b11000) & (state==IDLE). Non-branch opcodes never touch the table or counters.
- Table update on rq:
  - branch_taken_in=1: ctr[ridx] increments, saturating at 3.
  - branch_taken_in=0: ctr[ridx] decrements, saturating at 0.
  - Update is written at the clock edge ending the resolve cycle.
- Mispredict: mp = rq & (branch_taken_in != resolve_pred_taken_in).
- FSM states: IDLE, FLUSH.
  - IDLE, mp in cycle N → FLUSH. In cycle N+1:
    - redirect_valid_out=1.
    - redirect_pc_out = branch_taken_in ? resolve_target_in : resolve_pc_in+4 (as seen in cycle N).
    - flush_out=1; flush counter loaded with FLUSH_CYCLES-1.
  - FLUSH: redirect_valid_out=0 after the first cycle. flush_out stays 1 for exactly FLUSH_CYCLES cycles (N+1..N+FLUSH_CYCLES), then IDLE and flush_out=0.
  - FLUSH: resolve inputs are ignored (wrong path). No table update, no count, no new redirect.
  - Back-to-back: a mispredict resolved in the first IDLE cycle after FLUSH is accepted normally.
- mispredict_count_out increments by 1 on each accepted mp and holds at 16'hFFFF.
- Correct prediction: table update only; no redirect, no flush.
- Simultaneous fetch lookup and resolve update to the same index: fetch sees the old counter value.

Test Plan:
- Reset then fetch pc=0x100, opcode=11000, imm=0x20 → predict_taken_out=0, predict_pc_out=0x104; non-branch opcode 01100 → predict_taken_out=0.
- Resolve pc=0x100, pred=0, taken=1, target=0x120 in cycle N → in N+1: redirect_valid_out=1, redirect_pc_out=0x120, flush_out=1 for N+1..N+2; mispredict_count_out=1. Next fetch of pc=0x100 → predict_taken_out=1, predict_pc_out=0x120.
- Three taken resolves on pc=0x200, then one not-taken with pred=1 → counter 1→2→3(sat)→2; prediction still taken. Redirect_pc_out=0x204 on the not-taken mispredict.
- Resolve pc=0xFFFFFFFC, pred=1, taken=0 → redirect_pc_out=0x00000000 (wrap).
- Mispredict, then a second mispredicting resolve during FLUSH → ignored: count unchanged, table unchanged, no second redirect. The same resolve in the first IDLE cycle after FLUSH is accepted.
- Assert reset during FLUSH → flush_out, redirect_valid_out and count drop to 0 immediately; every entry predicts not-taken. Force the count to 16'hFFFF, then mispredict → count holds at FFFF.

Source files
------------

// File: rtl/msrv32_branch_predict_ctrl_if.sv
// Fetch/resolve/redirect signal bundle between the pipeline and the branch
// prediction controller.
interface msrv32_branch_predict_ctrl_if;
    logic        fetch_valid_in;
    logic [31:0] fetch_pc_in;
    logic [4:0]  fetch_opcode_in;
    logic [31:0] fetch_imm_in;
    logic        predict_taken_out;
    logic [31:0] predict_pc_out;
    logic        resolve_valid_in;
    logic [31:0] resolve_pc_in;
    logic [4:0]  resolve_opcode_in;
    logic        resolve_pred_taken_in;
    logic        branch_taken_in;
    logic [31:0] resolve_target_in;
    logic        redirect_valid_out;
    logic [31:0] redirect_pc_out;
    logic        flush_out;
    logic [15:0] mispredict_count_out;

    modport master (
        output fetch_valid_in, fetch_pc_in, fetch_opcode_in, fetch_imm_in,
        output resolve_valid_in, resolve_pc_in, resolve_opcode_in,
        output resolve_pred_taken_in, branch_taken_in, resolve_target_in,
        input  predict_taken_out, predict_pc_out,
        input  redirect_valid_out, redirect_pc_out, flush_out, mispredict_count_out
    );

    modport slave (
        input  fetch_valid_in, fetch_pc_in, fetch_opcode_in, fetch_imm_in,
        input  resolve_valid_in, resolve_pc_in, resolve_opcode_in,
        input  resolve_pred_taken_in, branch_taken_in, resolve_target_in,
        output predict_taken_out, predict_pc_out,
        output redirect_valid_out, redirect_pc_out, flush_out, mispredict_count_out
    );
endinterface

// File: rtl/msrv32_branch_predict_ctrl.sv
// Direct-mapped 2-bit counter branch predictor with mispredict redirect,
// multi-cycle flush and a saturating mispredict counter.
module msrv32_branch_predict_ctrl #(
    parameter int IDX_W        = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input logic ms_riscv32_mp_clk_in,
    input logic ms_riscv32_mp_rst_in,
    msrv32_branch_predict_ctrl_if.slave bp
);
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam int ENTRIES = 1 << IDX_W;

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t          state;
    logic [1:0]      ctr [ENTRIES];
    logic [2:0]      flush_cnt;
    logic [15:0]     mp_count;
    logic            redirect_valid;
    logic [31:0]     redirect_pc;
    logic            flush;
    logic [IDX_W-1:0] fidx;
    logic [IDX_W-1:0] ridx;
    logic            predict_taken;
    logic            rq;
    logic            mp;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    function automatic logic [15:0] sat_count(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    assign fidx = bp.fetch_pc_in[IDX_W+1:2];
    assign ridx = bp.resolve_pc_in[IDX_W+1:2];

    // Table read is the registered value, so a same-cycle update is not visible here.
    assign predict_taken = bp.fetch_valid_in & (bp.fetch_opcode_in == OPC_BRANCH) & ctr[fidx][1];
    assign bp.predict_taken_out = predict_taken;
    assign bp.predict_pc_out    = predict_taken ? bp.fetch_pc_in + bp.fetch_imm_in
                                                : bp.fetch_pc_in + 32'd4;

    assign rq = bp.resolve_valid_in & (bp.resolve_opcode_in == OPC_BRANCH) & (state == IDLE);
    assign mp = rq & (bp.branch_taken_in != bp.resolve_pred_taken_in);

    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'b01;
        end else if (rq) begin
            ctr[ridx] <= bp.branch_taken_in ? sat_inc(ctr[ridx]) : sat_dec(ctr[ridx]);
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state          <= IDLE;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush          <= 1'b0;
            flush_cnt      <= '0;
            mp_count       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    redirect_valid <= 1'b0;
                    if (mp) begin
                        state          <= FLUSH;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= bp.branch_taken_in ? bp.resolve_target_in
                                                             : bp.resolve_pc_in + 32'd4;
                        flush          <= 1'b1;
                        flush_cnt      <= 3'(FLUSH_CYCLES - 1);
                        mp_count       <= sat_count(mp_count);
                    end
                end
                FLUSH: begin
                    // Wrong-path resolves are dropped until the flush window closes.
                    redirect_valid <= 1'b0;
                    if (flush_cnt == 3'd0) begin
                        state <= IDLE;
                        flush <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bp.redirect_valid_out   = redirect_valid;
    assign bp.redirect_pc_out      = redirect_pc;
    assign bp.flush_out            = flush;
    assign bp.mispredict_count_out = mp_count;
endmodule

// File: tb/tb_msrv32_branch_predict_ctrl.sv
// Directed bench for msrv32_branch_predict_ctrl with hand-computed expectations.
module tb_msrv32_branch_predict_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    msrv32_branch_predict_ctrl_if bp();

    msrv32_branch_predict_ctrl #(.IDX_W(4), .FLUSH_CYCLES(2)) dut (
        .ms_riscv32_mp_clk_in(clk),
        .ms_riscv32_mp_rst_in(rst),
        .bp(bp.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [4:0] opc, input logic [31:0] imm);
        bp.fetch_valid_in  = 1'b1;
        bp.fetch_pc_in     = pc;
        bp.fetch_opcode_in = opc;
        bp.fetch_imm_in    = imm;
        #1;
    endtask

    task automatic set_resolve(input logic [31:0] pc, input logic pred, input logic taken,
                               input logic [31:0] target);
        bp.resolve_valid_in      = 1'b1;
        bp.resolve_pc_in         = pc;
        bp.resolve_opcode_in     = 5'b11000;
        bp.resolve_pred_taken_in = pred;
        bp.branch_taken_in       = taken;
        bp.resolve_target_in     = target;
    endtask

    // Presents one resolve for a single cycle; returns 1ns into the following cycle.
    task automatic do_resolve(input logic [31:0] pc, input logic pred, input logic taken,
                              input logic [31:0] target);
        @(negedge clk);
        set_resolve(pc, pred, taken, target);
        @(posedge clk);
        #1;
        bp.resolve_valid_in = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bp.fetch_valid_in = 1'b0;
        bp.fetch_pc_in = '0;
        bp.fetch_opcode_in = '0;
        bp.fetch_imm_in = '0;
        bp.resolve_valid_in = 1'b0;
        bp.resolve_pc_in = '0;
        bp.resolve_opcode_in = '0;
        bp.resolve_pred_taken_in = 1'b0;
        bp.branch_taken_in = 1'b0;
        bp.resolve_target_in = '0;
        cycles(3);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_redirect_valid", 32'(bp.redirect_valid_out), 32'd0);
        chk("rst_redirect_pc", bp.redirect_pc_out, 32'd0);
        chk("rst_flush", 32'(bp.flush_out), 32'd0);
        chk("rst_count", 32'(bp.mispredict_count_out), 32'd0);

        // Fresh table predicts not-taken; non-branch opcodes never predict taken.
        fetch(32'h100, 5'b11000, 32'h20);
        chk("init_pred_taken", 32'(bp.predict_taken_out), 32'd0);
        chk("init_pred_pc", bp.predict_pc_out, 32'h104);
        fetch(32'h100, 5'b01100, 32'h20);
        chk("nonbr_pred_taken", 32'(bp.predict_taken_out), 32'd0);

        // Mispredict on 0x100 with a same-cycle fetch of the same index.
        @(negedge clk);
        set_resolve(32'h100, 1'b0, 1'b1, 32'h120);
        fetch(32'h100, 5'b11000, 32'h20);
        chk("same_cycle_old_ctr", 32'(bp.predict_taken_out), 32'd0);
        @(posedge clk);
        #1;
        bp.resolve_valid_in = 1'b0;
        chk("mp1_redirect_valid", 32'(bp.redirect_valid_out), 32'd1);
        chk("mp1_redirect_pc", bp.redirect_pc_out, 32'h120);
        chk("mp1_flush_n1", 32'(bp.flush_out), 32'd1);
        chk("mp1_count", 32'(bp.mispredict_count_out), 32'd1);
        cycles(1);
        chk("mp1_redirect_pulse", 32'(bp.redirect_valid_out), 32'd0);
        chk("mp1_flush_n2", 32'(bp.flush_out), 32'd1);
        cycles(1);
        chk("mp1_flush_end", 32'(bp.flush_out), 32'd0);
        fetch(32'h100, 5'b11000, 32'h20);
        chk("mp1_pred_taken", 32'(bp.predict_taken_out), 32'd1);
        chk("mp1_pred_pc", bp.predict_pc_out, 32'h120);

        // Reset, then walk the 0x200 counter 1->2->3->3 with correct predictions.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do_resolve(32'h200, 1'b1, 1'b1, 32'h240);
            chk("tk_no_redirect", 32'(bp.redirect_valid_out), 32'd0);
            chk("tk_no_flush", 32'(bp.flush_out), 32'd0);
        end
        chk("tk_count", 32'(bp.mispredict_count_out), 32'd0);
        fetch(32'h200, 5'b11000, 32'h40);
        chk("sat3_pred_taken", 32'(bp.predict_taken_out), 32'd1);
        chk("sat3_pred_pc", bp.predict_pc_out, 32'h240);
        do_resolve(32'h200, 1'b1, 1'b0, 32'h240);
        chk("nt_redirect_valid", 32'(bp.redirect_valid_out), 32'd1);
        chk("nt_redirect_pc", bp.redirect_pc_out, 32'h204);
        chk("nt_count", 32'(bp.mispredict_count_out), 32'd1);
        cycles(2);
        chk("ctr2_pred_taken", 32'(bp.predict_taken_out), 32'd1);
        do_resolve(32'h200, 1'b1, 1'b0, 32'h240);
        chk("nt2_count", 32'(bp.mispredict_count_out), 32'd2);
        cycles(2);
        chk("ctr1_pred_taken", 32'(bp.predict_taken_out), 32'd0);
        chk("ctr1_pred_pc", bp.predict_pc_out, 32'h204);

        // Address wrap on both prediction and redirect.
        fetch(32'hFFFFFFFC, 5'b11000, 32'h10);
        chk("wrap_pred_pc", bp.predict_pc_out, 32'h0);
        do_resolve(32'hFFFFFFFC, 1'b1, 1'b0, 32'h0000000C);
        chk("wrap_redirect_pc", bp.redirect_pc_out, 32'h0);
        chk("wrap_count", 32'(bp.mispredict_count_out), 32'd3);

        // A mispredicting resolve held through FLUSH is ignored, then accepted in IDLE.
        @(negedge clk);
        set_resolve(32'h300, 1'b0, 1'b1, 32'h340);
        fetch(32'h300, 5'b11000, 32'h40);
        @(posedge clk);
        #1;
        chk("fl_ign_redirect", 32'(bp.redirect_valid_out), 32'd0);
        chk("fl_ign_flush", 32'(bp.flush_out), 32'd1);
        chk("fl_ign_count", 32'(bp.mispredict_count_out), 32'd3);
        cycles(1);
        chk("fl_ign_redirect2", 32'(bp.redirect_valid_out), 32'd0);
        chk("fl_ign_flush_end", 32'(bp.flush_out), 32'd0);
        chk("fl_ign_count2", 32'(bp.mispredict_count_out), 32'd3);
        chk("fl_ign_table", 32'(bp.predict_taken_out), 32'd0);
        cycles(1);
        bp.resolve_valid_in = 1'b0;
        chk("b2b_redirect_valid", 32'(bp.redirect_valid_out), 32'd1);
        chk("b2b_redirect_pc", bp.redirect_pc_out, 32'h340);
        chk("b2b_flush", 32'(bp.flush_out), 32'd1);
        chk("b2b_count", 32'(bp.mispredict_count_out), 32'd4);
        chk("b2b_table", 32'(bp.predict_taken_out), 32'd1);
        cycles(2);

        // Reset asserted mid-flush clears everything immediately.
        do_resolve(32'h400, 1'b0, 1'b1, 32'h500);
        chk("pre_rst_redirect", 32'(bp.redirect_valid_out), 32'd1);
        chk("pre_rst_count", 32'(bp.mispredict_count_out), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_redirect_valid", 32'(bp.redirect_valid_out), 32'd0);
        chk("arst_redirect_pc", bp.redirect_pc_out, 32'd0);
        chk("arst_flush", 32'(bp.flush_out), 32'd0);
        chk("arst_count", 32'(bp.mispredict_count_out), 32'd0);
        for (int i = 0; i < 16; i++) begin
            fetch(32'(i * 4), 5'b11000, 32'h80);
            chk("arst_entry_nt", 32'(bp.predict_taken_out), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Counter saturation at 16'hFFFF.
        @(negedge clk);
        force dut.mp_count = 16'hFFFE;
        #1;
        release dut.mp_count;
        do_resolve(32'h600, 1'b0, 1'b1, 32'h700);
        chk("cnt_to_ffff", 32'(bp.mispredict_count_out), 32'h0000FFFF);
        cycles(2);
        do_resolve(32'h680, 1'b0, 1'b1, 32'h700);
        chk("cnt_redirect", 32'(bp.redirect_valid_out), 32'd1);
        chk("cnt_hold_ffff", 32'(bp.mispredict_count_out), 32'h0000FFFF);
        cycles(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
